// File: rtl/seg7_scan_reader_16.sv
// Receive side of a two-digit multiplexed 7-segment display: debounces each strobed
// digit, pairs tens and ones into a frame, and reports the decoded 0..15 value or a reject code.
module seg7_scan_reader_16 #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:6] seg,
    input  logic [1:0] dig_sel,
    output logic [3:0] x,
    output logic       valid,
    output logic       err,
    output logic [1:0] err_code,
    output logic [1:0] fsm_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0]  STABLE_N  = 8'(STABLE_CYCLES);
    localparam logic [15:0] TIMEOUT_N = 16'(TIMEOUT);

    state_t          state;
    logic [0:6]      prev_seg;
    logic [1:0][7:0] cnt;
    logic [1:0][7:0] cnt_nxt;
    logic [1:0]      cap;
    logic [1:0]      hit;
    logic [1:0]      solo;
    logic [1:0][6:0] pat;
    logic [15:0]     tcnt;
    logic [4:0]      tens_dec;
    logic [4:0]      ones_dec;
    logic            range_bad;
    logic [3:0]      value;

    // Returns {recognised, digit}; anything outside 0..9 (dash included) is unrecognised.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0111111: decode = {1'b1, 4'd0};
            7'b0000110: decode = {1'b1, 4'd1};
            7'b1011011: decode = {1'b1, 4'd2};
            7'b1001111: decode = {1'b1, 4'd3};
            7'b1100110: decode = {1'b1, 4'd4};
            7'b1101101: decode = {1'b1, 4'd5};
            7'b1111101: decode = {1'b1, 4'd6};
            7'b0000111: decode = {1'b1, 4'd7};
            7'b1111111: decode = {1'b1, 4'd8};
            7'b1101111: decode = {1'b1, 4'd9};
            default:    decode = 5'd0;
        endcase
    endfunction

    assign solo      = {dig_sel == 2'b10, dig_sel == 2'b01};
    assign tens_dec  = decode(pat[1]);
    assign ones_dec  = decode(pat[0]);
    assign range_bad = (tens_dec[3:0] > 4'd1) || (tens_dec[3:0] == 4'd1 && ones_dec[3:0] > 4'd5);
    assign value     = (tens_dec[0] ? 4'd10 : 4'd0) + ones_dec[3:0];
    assign fsm_state = state;

    // A nonzero count implies this digit was strobed last cycle, so it also tracks strobe continuity.
    always_comb begin
        cnt_nxt = '0;
        hit     = '0;
        for (int d = 0; d < 2; d++) begin
            if (solo[d] && !cap[d]) begin
                if (cnt[d] == 8'd0) begin
                    cnt_nxt[d] = 8'd1;
                end else if (seg == prev_seg) begin
                    cnt_nxt[d] = cnt[d] + 8'd1;
                end
                hit[d] = (cnt_nxt[d] == STABLE_N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prev_seg <= '0;
            cnt      <= '0;
            cap      <= '0;
            pat      <= '0;
            tcnt     <= '0;
            x        <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else begin
            valid    <= 1'b0;
            err      <= 1'b0;
            prev_seg <= seg;
            cnt      <= cnt_nxt;
            for (int d = 0; d < 2; d++) begin
                if (hit[d]) begin
                    cap[d] <= 1'b1;
                    pat[d] <= seg;
                end
            end
            case (state)
                IDLE: begin
                    if (|hit) begin
                        state <= HALF;
                        tcnt  <= '0;
                    end
                end
                HALF: begin
                    // Timeout wins over a second acceptance on the same edge.
                    if (tcnt == TIMEOUT_N) begin
                        err      <= 1'b1;
                        err_code <= 2'd3;
                        cap      <= '0;
                        cnt      <= '0;
                        state    <= IDLE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                        if (|hit) state <= DONE;
                    end
                end
                DONE: begin
                    cap   <= '0;
                    state <= IDLE;
                    if (!tens_dec[4] || !ones_dec[4]) begin
                        err      <= 1'b1;
                        err_code <= 2'd1;
                    end else if (range_bad) begin
                        err      <= 1'b1;
                        err_code <= 2'd2;
                    end else begin
                        valid    <= 1'b1;
                        x        <= value;
                        err_code <= 2'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg7_scan_reader_16.sv
// Random and directed frames for seg7_scan_reader_16; expected pulses queued by a
// table-driven reference, popped and compared by an independent monitor.
module tb_seg7_scan_reader_16;
    localparam int ST = 4;
    localparam int TO = 1024;
    localparam logic [6:0] DASH = 7'b1000000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [0:6] seg = '0;
    logic [1:0] dig_sel = 2'b00;
    logic [3:0] x;
    logic       valid;
    logic       err;
    logic [1:0] err_code;
    logic [1:0] fsm_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Each entry is {is_err, x, err_code}; cyc_q holds the expected pulse cycle or -1.
    logic [6:0] exp_q[$];
    int         cyc_q[$];
    logic [3:0] model_x = 4'd0;
    logic [6:0] e;
    int         cq;

    logic [6:0] digit_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                   7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    seg7_scan_reader_16 #(.STABLE_CYCLES(ST), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel),
        .x(x), .valid(valid), .err(err), .err_code(err_code), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic drive(input logic [1:0] sel, input logic [6:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            seg     = p;
            dig_sel = sel;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void ref_decode(input logic [6:0] p, output logic ok, output int v);
        ok = 1'b0;
        v  = 0;
        for (int i = 0; i < 10; i++) begin
            if (digit_tab[i] == p) begin
                ok = 1'b1;
                v  = i;
            end
        end
    endfunction

    task automatic expect_frame(input logic [6:0] tp, input logic [6:0] op, input int at_cyc);
        logic tok, ook;
        int   tv, ov;
        ref_decode(tp, tok, tv);
        ref_decode(op, ook, ov);
        if (!tok || !ook) begin
            exp_q.push_back({1'b1, model_x, 2'd1});
        end else if (tv > 1 || (tv == 1 && ov > 5)) begin
            exp_q.push_back({1'b1, model_x, 2'd2});
        end else begin
            model_x = 4'(10 * tv + ov);
            exp_q.push_back({1'b0, model_x, 2'd0});
        end
        cyc_q.push_back(at_cyc);
    endtask

    // Second digit is held exactly ST cycles so the strobe is gone by the evaluation cycle.
    task automatic run_frame(input logic [6:0] tp, input logic [6:0] op, input logic ones_first,
                             input int n_first);
        int k;
        if (ones_first) begin
            drive(2'b01, op, n_first);
            k = cyc;
            drive(2'b10, tp, ST);
        end else begin
            drive(2'b10, tp, n_first);
            k = cyc;
            drive(2'b01, op, ST);
        end
        expect_frame(tp, op, k + ST + 1);
    endtask

    function automatic logic [6:0] pick_tens();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return digit_tab[$urandom_range(0, 1)];
        if (r < 8) return digit_tab[$urandom_range(0, 9)];
        if (r == 8) return DASH;
        return 7'($urandom);
    endfunction

    function automatic logic [6:0] pick_ones();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8) return digit_tab[$urandom_range(0, 9)];
        if (r == 8) return DASH;
        return 7'($urandom);
    endfunction

    always @(negedge clk) begin
        if (valid || err) begin
            check("valid_and_err", int'(valid & err), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", exp_q.size(), 1);
            end else begin
                e  = exp_q.pop_front();
                cq = cyc_q.pop_front();
                check("pulse_is_err", int'(err), int'(e[6]));
                check("x", int'(x), int'(e[5:2]));
                check("err_code", int'(err_code), int'(e[1:0]));
                if (cq >= 0) check("pulse_cycle", cyc, cq);
            end
        end
    end

    initial begin
        int k;
        drive(2'b00, 7'd0, 3);
        check("reset_x", int'(x), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_err", int'(err), 0);
        check("reset_err_code", int'(err_code), 0);
        check("reset_state", int'(fsm_state), 0);
        rst_n = 1'b1;
        drive(2'b00, 7'd0, 2);

        run_frame(digit_tab[0], digit_tab[3], 1'b0, ST);
        drive(2'b00, 7'd0, 2);
        run_frame(digit_tab[1], digit_tab[5], 1'b1, ST);
        drive(2'b00, 7'd0, 2);
        run_frame(digit_tab[1], digit_tab[6], 1'b0, ST);
        drive(2'b00, 7'd0, 2);
        run_frame(DASH, digit_tab[0], 1'b0, ST);
        drive(2'b00, 7'd0, 2);

        // Ones alone, tens never arrives.
        k = cyc;
        drive(2'b01, digit_tab[4], ST);
        exp_q.push_back({1'b1, model_x, 2'd3});
        cyc_q.push_back(k + ST + TO + 1);
        drive(2'b00, 7'd0, TO + 10);
        run_frame(digit_tab[0], digit_tab[7], 1'b0, ST);
        drive(2'b00, 7'd0, 2);

        // Ones pattern changes mid-count: only the new pattern may be accepted.
        drive(2'b10, digit_tab[0], ST + 1);
        drive(2'b01, digit_tab[2], 3);
        drive(2'b01, digit_tab[6], ST + 1);
        expect_frame(digit_tab[0], digit_tab[6], -1);
        drive(2'b00, 7'd0, 3);

        // Both strobes for one cycle restarts the count.
        drive(2'b10, digit_tab[1], ST + 1);
        drive(2'b01, digit_tab[3], 2);
        drive(2'b11, digit_tab[3], 1);
        k = cyc;
        drive(2'b01, digit_tab[3], ST);
        expect_frame(digit_tab[1], digit_tab[3], k + ST + 1);
        drive(2'b00, 7'd0, 3);

        // Too-short ones bursts leave nothing captured.
        drive(2'b01, digit_tab[2], 3);
        drive(2'b01, digit_tab[8], 3);
        drive(2'b00, 7'd0, 20);
        run_frame(digit_tab[1], digit_tab[2], 1'b0, ST);
        drive(2'b00, 7'd0, 2);
        run_frame(DASH, DASH, 1'b1, ST);
        drive(2'b00, 7'd0, 2);

        // Reset while a tens digit is held.
        drive(2'b10, digit_tab[1], ST);
        rst_n = 1'b0;
        #1;
        check("midreset_x", int'(x), 0);
        check("midreset_err_code", int'(err_code), 0);
        check("midreset_state", int'(fsm_state), 0);
        model_x = 4'd0;
        drive(2'b00, 7'd0, 2);
        check("midreset_valid", int'(valid), 0);
        check("midreset_err", int'(err), 0);
        rst_n = 1'b1;
        drive(2'b00, 7'd0, 1);
        run_frame(digit_tab[0], digit_tab[5], 1'b1, ST);
        drive(2'b00, 7'd0, 2);

        for (int f = 0; f < 150; f++) begin
            drive(2'b00, 7'($urandom), $urandom_range(0, 3));
            run_frame(pick_tens(), pick_ones(), 1'($urandom_range(0, 1)), $urandom_range(5, 8));
        end
        drive(2'b00, 7'd0, 10);
        check("pending_expected", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
